// File: rtl/rgb_pwm_ctrl.sv
// rgb_pwm_ctrl: three-channel PWM driver for the board RGB LED with shadow levels reloaded only at period boundaries.
// Hue-cycling FSM, step and divider counters are compiled in only when RGB_PWM_CYCLE_EN is defined.
module rgb_pwm_ctrl #(
   parameter int PWM_BITS  = 15,
   parameter int STEP_BITS = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [2:0]          led_toggle,
   input  logic [PWM_BITS-1:0] red_led_lvl,
   input  logic [PWM_BITS-1:0] green_led_lvl,
   input  logic [PWM_BITS-1:0] blue_led_lvl,
   input  logic [1:0]          rgb_cycle_speed_sel,
   output logic [2:0]          rgb_out,
   output logic                period_strobe,
   output logic [1:0]          cycle_phase
);

   localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
   localparam logic [PWM_BITS-1:0] CNT_ONE = PWM_BITS'(1);

   logic [PWM_BITS-1:0] r_pwm_cnt;
   logic [PWM_BITS-1:0] r_act [3];
   logic [PWM_BITS-1:0] w_static_lvl [3];
   logic [PWM_BITS-1:0] w_src_lvl [3];
   logic [2:0]          w_chan_on;
   logic [2:0]          w_rgb_next;
   logic [2:0]          r_rgb;
   logic                r_strobe;
   logic                w_boundary;

   assign w_boundary      = (r_pwm_cnt == CNT_MAX);
   assign w_static_lvl[0] = red_led_lvl;
   assign w_static_lvl[1] = green_led_lvl;
   assign w_static_lvl[2] = blue_led_lvl;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pwm_cnt <= '0;
         r_strobe  <= 1'b0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + CNT_ONE;
         r_strobe  <= w_boundary;
      end
   end

`ifdef RGB_PWM_CYCLE_EN
   typedef enum logic [1:0] {
      ST_RG = 2'd0,
      ST_GB = 2'd1,
      ST_BR = 2'd2
   } hue_state_t;

   localparam int                   LVL_SHIFT = PWM_BITS - STEP_BITS;
   localparam logic [STEP_BITS-1:0] STEP_MAX  = '1;
   localparam logic [STEP_BITS-1:0] STEP_ONE  = STEP_BITS'(1);

   hue_state_t           r_state;
   hue_state_t           w_state_next;
   logic [STEP_BITS-1:0] r_step;
   logic [STEP_BITS-1:0] w_step_next;
   logic [2:0]           r_div;
   logic [2:0]           w_div_next;
   logic [2:0]           w_div_limit;
   logic                 w_cyc;
   logic [PWM_BITS-1:0]  w_rise;
   logic [PWM_BITS-1:0]  w_fall;
   logic [PWM_BITS-1:0]  w_hue_lvl [3];

   assign w_cyc = led_toggle[1];

   always_comb begin
      w_div_limit = 3'd0;
      case (rgb_cycle_speed_sel)
         2'b00:   w_div_limit = 3'd0;
         2'b01:   w_div_limit = 3'd1;
         2'b10:   w_div_limit = 3'd3;
         default: w_div_limit = 3'd7;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_RG;
         r_step  <= '0;
         r_div   <= '0;
      end else begin
         r_state <= w_state_next;
         r_step  <= w_step_next;
         r_div   <= w_div_next;
      end
   end

   // Compare against the current limit with >= so lowering the rate mid-count fires at the next period.
   always_comb begin
      w_state_next = r_state;
      w_step_next  = r_step;
      w_div_next   = r_div;
      if (!w_cyc) begin
         w_state_next = ST_RG;
         w_step_next  = '0;
         w_div_next   = '0;
      end else if (w_boundary) begin
         if (r_div >= w_div_limit) begin
            w_div_next  = '0;
            w_step_next = r_step + STEP_ONE;
            if (r_step == STEP_MAX) begin
               case (r_state)
                  ST_RG:   w_state_next = ST_GB;
                  ST_GB:   w_state_next = ST_BR;
                  default: w_state_next = ST_RG;
               endcase
            end
         end else begin
            w_div_next = r_div + 3'd1;
         end
      end
   end

   // Levels derive from the post-update step so the shadow load sees the new hue.
   assign w_rise = PWM_BITS'(w_step_next) << LVL_SHIFT;
   assign w_fall = PWM_BITS'(~w_step_next) << LVL_SHIFT;

   always_comb begin
      w_hue_lvl[0] = '0;
      w_hue_lvl[1] = '0;
      w_hue_lvl[2] = '0;
      case (w_state_next)
         ST_RG: begin
            w_hue_lvl[0] = w_fall;
            w_hue_lvl[1] = w_rise;
         end
         ST_GB: begin
            w_hue_lvl[1] = w_fall;
            w_hue_lvl[2] = w_rise;
         end
         default: begin
            w_hue_lvl[2] = w_fall;
            w_hue_lvl[0] = w_rise;
         end
      endcase
   end

   for (genvar gi = 0; gi < 3; gi++) begin : g_src
      assign w_src_lvl[gi] = w_cyc ? w_hue_lvl[gi] : w_static_lvl[gi];
   end

   assign cycle_phase = r_state;
`else
   logic w_unused_cfg;

   assign w_unused_cfg = ^{led_toggle[1], rgb_cycle_speed_sel};

   for (genvar gi = 0; gi < 3; gi++) begin : g_src
      assign w_src_lvl[gi] = w_static_lvl[gi];
   end

   assign cycle_phase = 2'b00;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            r_act[i] <= '0;
         end
      end else if (w_boundary) begin
         for (int i = 0; i < 3; i++) begin
            r_act[i] <= w_src_lvl[i];
         end
      end
   end

   // Disabled channels park at the LED-off level, which is high for a common-anode part.
   for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      assign w_chan_on[gi]  = (r_pwm_cnt < r_act[gi]);
      assign w_rgb_next[gi] = led_toggle[0] ? (w_chan_on[gi] ^ led_toggle[2]) : led_toggle[2];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rgb <= 3'b000;
      end else begin
         r_rgb <= w_rgb_next;
      end
   end

   assign rgb_out       = r_rgb;
   assign period_strobe = r_strobe;

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Bench for rgb_pwm_ctrl: vector table of static levels, boundary/reset sequences, random stimulus vs a period-level model.
// Uses a short PWM period (PWM_BITS=8, STEP_BITS=4) so full hue cycles fit in the run.
module tb_rgb_pwm_ctrl;
   localparam int PB    = 8;
   localparam int SB    = 4;
   localparam int P     = 1 << PB;
   localparam int SN    = 1 << SB;
   localparam int SHIFT = PB - SB;
`ifdef RGB_PWM_CYCLE_EN
   localparam bit CYC_EN = 1'b1;
`else
   localparam bit CYC_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [2:0]    tog = 3'b000;
   logic [PB-1:0] lvl_r = '0, lvl_g = '0, lvl_b = '0;
   logic [1:0]    sel = 2'b00;
   logic [2:0]    rgb_out;
   logic          period_strobe;
   logic [1:0]    cycle_phase;

   int total = 0;
   int bad   = 0;

   // Reference model state: elapsed clocks, shadow levels and hue position.
   int         m_t;
   int         m_act [3];
   int         m_step, m_phase, m_div;
   logic [2:0] e_rgb;
   logic       e_strobe;
   logic [1:0] e_phase;
   int         e_pos;
   int         win_err;
   string      win_msg;

   typedef struct {
      logic [2:0]    tog;
      logic [PB-1:0] r, g, b;
      int            hr, hg, hb;
   } vec_t;
   vec_t vecs [6];

   rgb_pwm_ctrl #(.PWM_BITS(PB), .STEP_BITS(SB)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .led_toggle          (tog),
      .red_led_lvl         (lvl_r),
      .green_led_lvl       (lvl_g),
      .blue_led_lvl        (lvl_b),
      .rgb_cycle_speed_sel (sel),
      .rgb_out             (rgb_out),
      .period_strobe       (period_strobe),
      .cycle_phase         (cycle_phase)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int got, input int want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic check_window(input string name);
      total++;
      if (win_err != 0) begin
         bad++;
         $display("FAIL %s: %0d cycle mismatches, first %s", name, win_err, win_msg);
      end
      win_err = 0;
   endtask

   function automatic int hue_lvl(input int ch, input int ph, input int st);
      if (ch == ph) return (SN - 1 - st) << SHIFT;
      if (ch == (ph + 1) % 3) return st << SHIFT;
      return 0;
   endfunction

   function automatic int static_lvl(input int ch);
      if (ch == 0) return int'(lvl_r);
      if (ch == 1) return int'(lvl_g);
      return int'(lvl_b);
   endfunction

   task automatic model_reset();
      m_t = 0;
      for (int i = 0; i < 3; i++) m_act[i] = 0;
      m_step  = 0;
      m_phase = 0;
      m_div   = 0;
      win_err = 0;
   endtask

   // One clock: advance the model at the rising edge, compare the DUT on the falling edge.
   task automatic tick();
      int pos;
      bit cyc;
      int idx;
      @(posedge clk);
      pos = m_t % P;
      cyc = CYC_EN && tog[1];
      for (int i = 0; i < 3; i++)
         e_rgb[i] = tog[0] ? ((pos < m_act[i]) ^ tog[2]) : tog[2];
      e_strobe = (pos == P - 1);
      if (pos == P - 1) begin
         if (cyc) begin
            if (m_div >= (1 << sel) - 1) begin
               m_div   = 0;
               idx     = (m_phase * SN + m_step + 1) % (3 * SN);
               m_phase = idx / SN;
               m_step  = idx % SN;
            end else begin
               m_div++;
            end
         end
         for (int i = 0; i < 3; i++)
            m_act[i] = cyc ? hue_lvl(i, m_phase, m_step) : static_lvl(i);
      end
      if (!cyc) begin
         m_step  = 0;
         m_phase = 0;
         m_div   = 0;
      end
      m_t++;
      e_phase = 2'(m_phase);
      e_pos   = pos;
      @(negedge clk);
      if ({rgb_out, period_strobe, cycle_phase} !== {e_rgb, e_strobe, e_phase}) begin
         win_err++;
         if (win_err == 1)
            win_msg = $sformatf("t=%0d rgb=%b/%b strobe=%b/%b phase=%0d/%0d",
                                m_t, rgb_out, e_rgb, period_strobe, e_strobe, cycle_phase, e_phase);
      end
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic run_count(input int n, output int hr, output int hg, output int hb, output int hs);
      hr = 0; hg = 0; hb = 0; hs = 0;
      for (int k = 0; k < n; k++) begin
         tick();
         hr += int'(rgb_out[0]);
         hg += int'(rgb_out[1]);
         hb += int'(rgb_out[2]);
         hs += int'(period_strobe);
      end
   endtask

   task automatic align_to(input int pos);
      for (int k = 0; k < 2 * P; k++) begin
         tick();
         if (e_pos == pos) break;
      end
   endtask

   initial begin
      int hr, hg, hb, hs, n;
      vecs[0] = '{tog: 3'b001, r: 8'd128, g: 8'd0,   b: 8'd255, hr: 128, hg: 0,   hb: 255};
      vecs[1] = '{tog: 3'b101, r: 8'd0,   g: 8'd0,   b: 8'd0,   hr: 256, hg: 256, hb: 256};
      vecs[2] = '{tog: 3'b100, r: 8'd50,  g: 8'd60,  b: 8'd70,  hr: 256, hg: 256, hb: 256};
      vecs[3] = '{tog: 3'b000, r: 8'd50,  g: 8'd60,  b: 8'd70,  hr: 0,   hg: 0,   hb: 0};
      vecs[4] = '{tog: 3'b001, r: 8'd1,   g: 8'd254, b: 8'd37,  hr: 1,   hg: 254, hb: 37};
      vecs[5] = '{tog: 3'b101, r: 8'd1,   g: 8'd128, b: 8'd255, hr: 255, hg: 128, hb: 1};

      model_reset();
      #22;
      check("reset_rgb", int'(rgb_out), 0);
      check("reset_strobe", int'(period_strobe), 0);
      check("reset_phase", int'(cycle_phase), 0);

      @(negedge clk);
      tog = 3'b001; lvl_r = 8'd128; lvl_g = 8'd0; lvl_b = 8'd255;
      rst = 1'b1;
      run_count(P, hr, hg, hb, hs);
      check("first_period_red", hr, 0);
      check("first_period_strobe", hs, 1);
      check_window("first_period_model");

      for (int v = 0; v < 6; v++) begin
         tog = vecs[v].tog; lvl_r = vecs[v].r; lvl_g = vecs[v].g; lvl_b = vecs[v].b;
         run(2 * P);
         run_count(P, hr, hg, hb, hs);
         $display("vec %0d tog=%b lvl=%0d/%0d/%0d high=%0d/%0d/%0d", v, vecs[v].tog,
                  vecs[v].r, vecs[v].g, vecs[v].b, hr, hg, hb);
         check($sformatf("vec%0d_red", v), hr, vecs[v].hr);
         check($sformatf("vec%0d_green", v), hg, vecs[v].hg);
         check($sformatf("vec%0d_blue", v), hb, vecs[v].hb);
         check($sformatf("vec%0d_strobe", v), hs, 1);
         check_window($sformatf("vec%0d_model", v));
      end

      // Mid-period write holds off until the next boundary.
      tog = 3'b001; lvl_r = 8'd16;
      run(2 * P);
      align_to(P - 1);
      hr = 0;
      for (int k = 0; k < P; k++) begin
         tick();
         hr += int'(rgb_out[0]);
         if (e_pos == 100) lvl_r = 8'd64;
      end
      check("midwrite_cur_period", hr, 16);
      run_count(P, hr, hg, hb, hs);
      check("midwrite_next_period", hr, 64);
      check_window("midwrite_model");

      // Value present at the max-count clock is captured; one clock later is not.
      lvl_g = 8'd20;
      run(2 * P);
      align_to(P - 2);
      lvl_g = 8'd200;
      tick();
      lvl_g = 8'd10;
      run_count(P, hr, hg, hb, hs);
      check("boundary_capture", hg, 200);
      run_count(P, hr, hg, hb, hs);
      check("boundary_late", hg, 10);
      check_window("boundary_model");

`ifdef RGB_PWM_CYCLE_EN
      sel = 2'b00;
      align_to(P - 1);
      tog = 3'b011;
      n = 0;
      for (int k = 0; k < 4 * SN * P; k++) begin
         tick();
         n += int'(period_strobe);
         if (cycle_phase == 2'd1) break;
      end
      check("cycle_periods_to_gb", n, SN);
      run_count(P, hr, hg, hb, hs);
      check("cycle_gb_red", hr, 0);
      check("cycle_gb_green", hg, (SN - 1) << SHIFT);
      n += hs;
      for (int k = 0; k < 4 * SN * P; k++) begin
         tick();
         n += int'(period_strobe);
         if (cycle_phase == 2'd0) break;
      end
      check("cycle_periods_full", n, 3 * SN);
      check_window("cycle_model");

      tog = 3'b001;
      align_to(P - 1);
      tog = 3'b011; sel = 2'b11;
      run(3 * P);
      sel = 2'b00;
      run(P);
      run_count(P, hr, hg, hb, hs);
      check("sel_drop_red", hr, (SN - 2) << SHIFT);
      check("sel_drop_green", hg, 1 << SHIFT);
      check_window("sel_drop_model");
`endif

      for (int s = 0; s < 40; s++) begin
         tog   = 3'($urandom);
         lvl_r = PB'($urandom);
         lvl_g = PB'($urandom);
         lvl_b = PB'($urandom);
         sel   = 2'($urandom);
         n     = int'($urandom_range(1, 2 * P));
         run(n);
         $display("rand %0d tog=%b lvl=%0d/%0d/%0d sel=%0d clocks=%0d", s, tog, lvl_r, lvl_g, lvl_b, sel, n);
         check_window($sformatf("rand%0d_model", s));
      end

      // Asynchronous reset mid-period with red driving high.
      tog = 3'b001; lvl_r = 8'd255; sel = 2'b00;
      run(2 * P);
      align_to(50);
      check("pre_reset_red", int'(rgb_out[0]), 1);
      #1 rst = 1'b0;
      #1;
      check("async_reset_rgb", int'(rgb_out), 0);
      check("async_reset_strobe", int'(period_strobe), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      n = 2 * P;
      for (int k = 0; k < 2 * P; k++) begin
         tick();
         if (period_strobe) begin
            n = k + 1;
            break;
         end
      end
      check("post_reset_first_strobe", n, P);
      run(P);
      check_window("post_reset_model");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
